dac_stream_sequencer: RTL and testbench
=======================================

Name: dac_stream_sequencer

Overview:
- Front-end controller for the stereo sigma-delta DAC core.
- Buffers incoming stereo PCM samples in a small FIFO.
- Issues one sample to the DAC per sample-rate tick from a programmable divider.
- Applies a click-free soft-mute gain ramp on enable/disable, and holds the DAC configuration registers (trims, mode), writable through a simple config port.

Parameters:
- OSR_DIV, 64, clocks per sample tick (>=2).
- FIFO_DEPTH, 4, sample FIFO entries (power of 2).
- RAMP_STEP, 16, gain increment per tick during ramps (1..256).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- enable  in  1  level: 1 = play, 0 = soft-mute to idle
- s_valid  in  1  upstream sample valid
- s_ready  out  1  upstream ready (= FIFO not full)
- s_l  in  24  left sample, signed
- s_r  in  24  right sample, signed
- cfg_we  in  1  config write strobe
- cfg_addr  in  2  0 = trim_l, 1 = trim_r, 2 = mode, 3 = reserved
- cfg_wdata  in  12  config write data
- underrun_clr  in  1  clears sticky underrun
- dac_valid  out  1  one-cycle pulse, new dac_l/dac_r
- dac_l  out  24  scaled left sample, signed
- dac_r  out  24  scaled right sample, signed
- mode_multibit  out  1  DAC mode register (cfg_wdata[0])
- trim_l  out  12  left trim register
- trim_r  out  12  right trim register
- state  out  2  FSM state: 0 IDLE, 1 RAMP_UP, 2 RUN, 3 RAMP_DOWN
- underrun  out  1  sticky underrun flag
- fifo_level  out  $clog2(FIFO_DEPTH)+1  current occupancy

Behaviour:
- Reset values: all outputs 0, FIFO empty, gain 0, divider 0, state IDLE; s_ready is 1 once out of reset.
- Config writes:
  - cfg_we samples cfg_addr/cfg_wdata; the register updates on that clock edge and is visible the next cycle.
  - addr 3 writes are ignored. Config is accepted in any state.
- FIFO:
  - Push when s_valid && s_ready; s_ready = !full, registered occupancy only.
  - Pop only on a tick, in non-IDLE states, when not empty.
  - Push and pop in the same cycle are both legal; level is unchanged.
  - No bypass: a push into an empty FIFO on a tick cycle is not popped that tick.
- Divider:
  - Counts 0..OSR_DIV-1 in non-IDLE states; held at 0 in IDLE.
  - tick = (count == OSR_DIV-1).
- Tick action, registered; results visible the cycle after the tick:
  - If the FIFO is non-empty, pop into the last_sample pair; otherwise reuse last_sample (hold).
  - Output = (last_sample × gain) >>> 8, where gain is 9 bits (0..256) and is the pre-update value.
  - Computed at 33-bit signed, then truncated to 24 bits. Arithmetic shift floors toward −inf.
  - gain = 256 gives exact pass-through.
  - dac_valid pulses for exactly 1 cycle per tick.
- Underrun: in RUN, a tick with an empty FIFO sets underrun (sticky). Empty ticks in ramp states hold silently.
- underrun_clr: clears the flag; if a set occurs in the same cycle, the set wins.
- FSM:
  - IDLE: dac_l/dac_r forced 0, no dac_valid. enable=1 → RAMP_UP.
  - RAMP_UP: each tick, gain = min(gain+RAMP_STEP, 256). When the updated gain = 256 → RUN. enable=0 → RAMP_DOWN immediately, keeping the current gain.
  - RUN: enable=0 → RAMP_DOWN.
  - RAMP_DOWN: each tick, gain = max(gain−RAMP_STEP, 0). When the updated gain = 0 → IDLE, flush FIFO, clear last_sample. enable=1 → RAMP_UP from the current gain.
- Gain is continuous across ramp reversals; it never jumps.
- Reset mid-operation returns everything to reset values immediately (async); config registers also reset.

Test Plan:
- Reset/config:
  - Assert rst_n=0 mid-RUN → all outputs 0, state 0, s_ready 1 after release.
  - Write cfg addr0=0x7FF, addr2=1 → trim_l=0x7FF, mode_multibit=1 next cycle.
  - Write addr3 → no register change.
- Ramp up (OSR_DIV=4, RAMP_STEP=64), FIFO prefilled with s_l=0x100000:
  - enable=1 → dac_valid every 4 clocks; dac_l sequence 0x000000, 0x040000, 0x080000, 0x0C0000, 0x100000.
  - state = RUN after the 4th tick.
- Negative rounding: s_l=−0x000001 at gain 128 → dac_l=0xFFFFFF (floor). s_r=−0x100000 at gain 128 → 0xF80000.
- Underrun: in RUN with the FIFO drained → dac_l repeats the last sample and underrun=1. Pulse underrun_clr with no new empty tick → underrun=0.
- FIFO full: FIFO_DEPTH=4, 4 pushes with no tick → s_ready=0, fifo_level=4. A 5th s_valid is not accepted. After a tick pops one → s_ready=1.
- Ramp reversal: enable=0 at gain 192, then enable=1 after 1 tick → gain 128, then back up 192, 256 → RUN. Full ramp-down to 0 → IDLE, fifo_level=0.

Source files
------------

// File: rtl/dac_stream_sequencer.sv
// dac_stream_sequencer
// Front-end controller for the stereo sigma-delta DAC core. Buffers stereo
// PCM samples in a small FIFO and issues one gain-scaled sample pair per
// sample-rate tick. It applies a click-free gain ramp when playback is
// enabled or disabled, and holds the DAC configuration registers.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   enable              1 = play, 0 = soft-mute down to idle
//   s_valid/s_ready     upstream sample handshake (s_ready = FIFO not full)
//   s_l, s_r            signed 24-bit left/right input samples
//   cfg_we/addr/wdata   config write port (0 trim_l, 1 trim_r, 2 mode, 3 ignored)
//   underrun_clr        clears the sticky underrun flag
//   dac_valid           one-cycle pulse per tick, new dac_l/dac_r
//   dac_l, dac_r        scaled signed 24-bit output samples
//   mode_multibit       DAC mode register
//   trim_l, trim_r      DAC trim registers
//   state               FSM state (0 IDLE, 1 RAMP_UP, 2 RUN, 3 RAMP_DOWN)
//   underrun            sticky underrun flag
//   fifo_level          current FIFO occupancy
module dac_stream_sequencer #(
  parameter int unsigned OSR_DIV    = 64,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned RAMP_STEP  = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          enable,
  input  logic                          s_valid,
  output logic                          s_ready,
  input  logic [23:0]                   s_l,
  input  logic [23:0]                   s_r,
  input  logic                          cfg_we,
  input  logic [1:0]                    cfg_addr,
  input  logic [11:0]                   cfg_wdata,
  input  logic                          underrun_clr,
  output logic                          dac_valid,
  output logic [23:0]                   dac_l,
  output logic [23:0]                   dac_r,
  output logic                          mode_multibit,
  output logic [11:0]                   trim_l,
  output logic [11:0]                   trim_r,
  output logic [1:0]                    state,
  output logic                          underrun,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned LW = AW + 1;
  localparam int unsigned CW = $clog2(OSR_DIV);
  localparam logic [CW-1:0] CNT_MAX   = CW'(OSR_DIV - 1);
  localparam logic [LW-1:0] LVL_FULL  = LW'(FIFO_DEPTH);
  localparam logic [9:0]    STEP      = 10'(RAMP_STEP);
  localparam logic [9:0]    FULL_GAIN = 10'd256;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RAMP_UP   = 2'd1,
    RUN       = 2'd2,
    RAMP_DOWN = 2'd3
  } state_t;

  state_t state_q, state_n;

  logic [8:0]    gain_q, gain_n;
  logic [9:0]    gain_up, gain_dn;
  logic [CW-1:0] div_cnt;
  logic          tick;
  logic          flush;

  logic [47:0]   fifo_mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [LW-1:0] count;
  logic          push, pop;

  logic [23:0]        last_l, last_r;
  logic [23:0]        src_l, src_r;
  logic signed [32:0] prod_l, prod_r;
  logic [23:0]        scaled_l, scaled_r;

  assign state      = state_q;
  assign fifo_level = count;

  // Divider is held at 0 in IDLE, so tick can only fire in active states.
  assign tick    = (state_q != IDLE) && (div_cnt == CNT_MAX);
  assign s_ready = (count != LVL_FULL);
  assign push    = s_valid && s_ready;
  // Pop looks at registered occupancy only: a sample pushed on a tick cycle
  // is not eligible until the following tick.
  assign pop     = tick && (count != '0);

  // Sample used on a tick: freshly popped pair, otherwise the held pair.
  assign src_l = pop ? fifo_mem[rd_ptr][47:24] : last_l;
  assign src_r = pop ? fifo_mem[rd_ptr][23:0]  : last_r;

  // 33-bit signed product keeps the low bits identical to a full-width
  // multiply; gain is zero-extended so it is always non-negative.
  assign prod_l   = $signed({{9{src_l[23]}}, src_l}) * $signed({24'd0, gain_q});
  assign prod_r   = $signed({{9{src_r[23]}}, src_r}) * $signed({24'd0, gain_q});
  assign scaled_l = 24'(prod_l >>> 8);
  assign scaled_r = 24'(prod_r >>> 8);

  // Next-state and gain update
  always_comb begin
    state_n = state_q;
    gain_n  = gain_q;
    flush   = 1'b0;
    gain_up = {1'b0, gain_q} + STEP;
    if (gain_up > FULL_GAIN) begin
      gain_up = FULL_GAIN;
    end
    gain_dn = ({1'b0, gain_q} > STEP) ? ({1'b0, gain_q} - STEP) : '0;

    case (state_q)
      IDLE: begin
        if (enable) begin
          state_n = RAMP_UP;
        end
      end
      RAMP_UP: begin
        // Reversal keeps the current gain; the ramp continues from there.
        if (!enable) begin
          state_n = RAMP_DOWN;
        end else if (tick) begin
          gain_n = gain_up[8:0];
          if (gain_up == FULL_GAIN) begin
            state_n = RUN;
          end
        end
      end
      RUN: begin
        if (!enable) begin
          state_n = RAMP_DOWN;
        end
      end
      RAMP_DOWN: begin
        if (enable) begin
          state_n = RAMP_UP;
        end else if (tick) begin
          gain_n = gain_dn[8:0];
          if (gain_dn == '0) begin
            state_n = IDLE;
            flush   = 1'b1;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // State, gain and divider
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      gain_q  <= '0;
      div_cnt <= '0;
    end else begin
      state_q <= state_n;
      gain_q  <= gain_n;
      if (state_q == IDLE || tick) begin
        div_cnt <= '0;
      end else begin
        div_cnt <= div_cnt + CW'(1);
      end
    end
  end

  // FIFO storage (no reset needed; validity is tracked by count)
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= {s_l, s_r};
    end
  end

  // FIFO pointers and occupancy; flush on entry to IDLE overrides push/pop
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + LW'(1);
        2'b01:   count <= count - LW'(1);
        default: count <= count;
      endcase
    end
  end

  // Held sample pair, output datapath and underrun flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_l    <= '0;
      last_r    <= '0;
      dac_valid <= 1'b0;
      dac_l     <= '0;
      dac_r     <= '0;
      underrun  <= 1'b0;
    end else begin
      if (flush) begin
        last_l <= '0;
        last_r <= '0;
      end else if (pop) begin
        last_l <= src_l;
        last_r <= src_r;
      end

      dac_valid <= tick;
      if (tick) begin
        dac_l <= scaled_l;
        dac_r <= scaled_r;
      end else if (state_q == IDLE) begin
        dac_l <= '0;
        dac_r <= '0;
      end

      // A new underrun in the same cycle as a clear wins.
      if (tick && (state_q == RUN) && (count == '0)) begin
        underrun <= 1'b1;
      end else if (underrun_clr) begin
        underrun <= 1'b0;
      end
    end
  end

  // Config registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      trim_l        <= '0;
      trim_r        <= '0;
      mode_multibit <= 1'b0;
    end else if (cfg_we) begin
      case (cfg_addr)
        2'd0:    trim_l        <= cfg_wdata;
        2'd1:    trim_r        <= cfg_wdata;
        2'd2:    mode_multibit <= cfg_wdata[0];
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dac_stream_sequencer.sv
// Directed self-checking bench for dac_stream_sequencer with OSR_DIV=4,
// FIFO_DEPTH=4, RAMP_STEP=64. Inputs are driven and outputs sampled 1 time
// unit after the rising edge.
module tb_dac_stream_sequencer;

  logic        clk;
  logic        rst_n;
  logic        enable;
  logic        s_valid;
  logic        s_ready;
  logic [23:0] s_l, s_r;
  logic        cfg_we;
  logic [1:0]  cfg_addr;
  logic [11:0] cfg_wdata;
  logic        underrun_clr;
  logic        dac_valid;
  logic [23:0] dac_l, dac_r;
  logic        mode_multibit;
  logic [11:0] trim_l, trim_r;
  logic [1:0]  state;
  logic        underrun;
  logic [2:0]  fifo_level;

  int checks = 0;
  int errors = 0;
  int n;

  logic [23:0] ramp_l [5];
  logic [23:0] ramp_r [5];

  dac_stream_sequencer #(
    .OSR_DIV   (4),
    .FIFO_DEPTH(4),
    .RAMP_STEP (64)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .enable       (enable),
    .s_valid      (s_valid),
    .s_ready      (s_ready),
    .s_l          (s_l),
    .s_r          (s_r),
    .cfg_we       (cfg_we),
    .cfg_addr     (cfg_addr),
    .cfg_wdata    (cfg_wdata),
    .underrun_clr (underrun_clr),
    .dac_valid    (dac_valid),
    .dac_l        (dac_l),
    .dac_r        (dac_r),
    .mode_multibit(mode_multibit),
    .trim_l       (trim_l),
    .trim_r       (trim_r),
    .state        (state),
    .underrun     (underrun),
    .fifo_level   (fifo_level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Advance until dac_valid is seen or the budget runs out; n = cycles taken.
  task automatic wait_valid(output int cnt);
    cnt = 0;
    do begin
      cyc();
      cnt++;
    end while (!dac_valid && cnt < 12);
    check("valid_seen", {31'd0, dac_valid}, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    ramp_l = '{24'h000000, 24'h040000, 24'h080000, 24'h0C0000, 24'h100000};
    ramp_r = '{24'h000000, 24'h020000, 24'h040000, 24'h060000, 24'h080000};

    rst_n = 1'b0; enable = 1'b0; s_valid = 1'b0; s_l = '0; s_r = '0;
    cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0; underrun_clr = 1'b0;
    repeat (3) cyc();
    check("rst_state", {30'd0, state}, 0);
    check("rst_valid", {31'd0, dac_valid}, 0);
    check("rst_level", {29'd0, fifo_level}, 0);
    check("rst_dac_l", {8'd0, dac_l}, 0);
    rst_n = 1'b1;
    cyc();
    check("rst_s_ready", {31'd0, s_ready}, 1);

    // Config writes, including an ignored address 3
    cfg_we = 1'b1; cfg_addr = 2'd0; cfg_wdata = 12'h7FF;
    cyc();
    check("trim_l", {20'd0, trim_l}, 32'h7FF);
    cfg_addr = 2'd2; cfg_wdata = 12'h001;
    cyc();
    check("mode", {31'd0, mode_multibit}, 1);
    cfg_addr = 2'd1; cfg_wdata = 12'h123;
    cyc();
    check("trim_r", {20'd0, trim_r}, 32'h123);
    cfg_addr = 2'd3; cfg_wdata = 12'hABC;
    cyc();
    cfg_we = 1'b0;
    check("addr3_trim_l", {20'd0, trim_l}, 32'h7FF);
    check("addr3_trim_r", {20'd0, trim_r}, 32'h123);
    check("addr3_mode", {31'd0, mode_multibit}, 1);

    // Fill FIFO in IDLE; a fifth sample must be refused
    s_valid = 1'b1; s_l = 24'h100000; s_r = 24'h080000;
    repeat (4) cyc();
    check("full_level", {29'd0, fifo_level}, 4);
    check("full_ready", {31'd0, s_ready}, 0);
    s_l = 24'h7FFFFF;
    cyc();
    check("fifth_refused", {29'd0, fifo_level}, 4);
    s_valid = 1'b0;

    // Ramp up to RUN
    enable = 1'b1;
    cyc();
    check("ramp_up_state", {30'd0, state}, 1);
    for (int i = 0; i < 5; i++) begin
      wait_valid(n);
      check($sformatf("tick_spacing%0d", i), n, 4);
      check($sformatf("ramp_l%0d", i), {8'd0, dac_l}, {8'd0, ramp_l[i]});
      check($sformatf("ramp_r%0d", i), {8'd0, dac_r}, {8'd0, ramp_r[i]});
      if (i == 0) begin
        check("pop_level", {29'd0, fifo_level}, 3);
        check("pop_ready", {31'd0, s_ready}, 1);
      end
      if (i == 3) begin
        check("run_state", {30'd0, state}, 2);
      end
    end
    // Fifth tick in RUN had an empty FIFO: held sample repeated, underrun set
    check("underrun_set", {31'd0, underrun}, 1);
    underrun_clr = 1'b1;
    cyc();
    underrun_clr = 1'b0;
    check("underrun_clr", {31'd0, underrun}, 0);
    check("valid_one_cycle", {31'd0, dac_valid}, 0);

    // Negative samples, then ramp down with a reversal at gain 128
    s_valid = 1'b1; s_l = 24'hFFFFFF; s_r = 24'hF00000;
    cyc();
    s_valid = 1'b0;
    check("neg_level", {29'd0, fifo_level}, 1);
    enable = 1'b0;
    cyc();
    check("ramp_down_state", {30'd0, state}, 3);
    wait_valid(n);
    check("neg256_l", {8'd0, dac_l}, 32'hFFFFFF);
    check("neg256_r", {8'd0, dac_r}, 32'hF00000);
    wait_valid(n);
    check("neg192_l", {8'd0, dac_l}, 32'hFFFFFF);
    check("neg192_r", {8'd0, dac_r}, 32'hF40000);
    enable = 1'b1;
    wait_valid(n);
    check("rev_state", {30'd0, state}, 1);
    check("neg128_l", {8'd0, dac_l}, 32'hFFFFFF);
    check("neg128_r", {8'd0, dac_r}, 32'hF80000);
    wait_valid(n);
    check("rev192_r", {8'd0, dac_r}, 32'hF40000);
    check("rev_run_state", {30'd0, state}, 2);

    // Full ramp down to IDLE with samples still queued
    enable = 1'b0;
    wait_valid(n);
    check("down256_r", {8'd0, dac_r}, 32'hF00000);
    wait_valid(n);
    check("down192_r", {8'd0, dac_r}, 32'hF40000);
    wait_valid(n);
    check("down128_r", {8'd0, dac_r}, 32'hF80000);
    s_valid = 1'b1; s_l = 24'h200000; s_r = 24'h000000;
    cyc();
    cyc();
    s_valid = 1'b0;
    check("queued_level", {29'd0, fifo_level}, 2);
    wait_valid(n);
    check("idle_state", {30'd0, state}, 0);
    check("idle_flush", {29'd0, fifo_level}, 0);
    cyc();
    check("idle_dac_l", {8'd0, dac_l}, 0);
    check("idle_valid", {31'd0, dac_valid}, 0);
    check("idle_ready", {31'd0, s_ready}, 1);

    // Reset in the middle of RUN
    enable = 1'b1;
    n = 0;
    do begin
      cyc();
      n++;
    end while (state != 2'd2 && n < 40);
    check("rerun_state", {30'd0, state}, 2);
    repeat (5) cyc();
    check("rerun_underrun", {31'd0, underrun}, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_state", {30'd0, state}, 0);
    check("async_trim_l", {20'd0, trim_l}, 0);
    check("async_mode", {31'd0, mode_multibit}, 0);
    check("async_underrun", {31'd0, underrun}, 0);
    check("async_level", {29'd0, fifo_level}, 0);
    check("async_valid", {31'd0, dac_valid}, 0);
    enable = 1'b0;
    cyc();
    rst_n = 1'b1;
    cyc();
    check("post_rst_ready", {31'd0, s_ready}, 1);
    check("post_rst_state", {30'd0, state}, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
